// File: rtl/fft16_frame_sched.sv
// fft16_frame_sched
//   Two-channel frame scheduler in front of a 16-point serial FFT core.
//   A round-robin arbiter grants one channel, 16 samples are streamed into
//   the core (zero-padded when the granted channel stalls), and the 16
//   result beats from the core are tagged with channel, bin index and last.
//   Only one frame is in flight at a time.
//
//   Optional feature macro: FFT16_SCHED_TIMEOUT_EN
//     When defined, a watchdog in WAIT aborts the frame and pulses
//     timeout_err_o if the first core beat does not arrive within
//     TIMEOUT_CYCLES cycles, or if core_valid_i drops mid-result.
//     When undefined, timeout_err_o is tied low and WAIT waits forever.
//
// Ports
//   sys_clk_i, rst_n_i          clock (rising edge), async active-low reset
//   chN_valid_i/real/imag       per-channel sample; valid doubles as request
//   chN_ready_o                 high only for the granted channel in LOAD
//   fft_valid_o/real/imag       registered serial frame to the core
//   core_valid_i/real/imag      serial results from the core
//   out_valid_o/real/imag       registered result stream
//   out_ch_o, out_idx_o         channel tag and bin index 0..15
//   out_last_o                  pulses with bin 15
//   busy_o                      FSM not idle
//   underrun_o                  pulses alongside each zero-padded sample
//   timeout_err_o               watchdog pulse (0 without the macro)
module fft16_frame_sched #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned OUT_WIDTH      = 18,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                         sys_clk_i,
  input  logic                         rst_n_i,
  input  logic                         ch0_valid_i,
  input  logic signed [DATA_WIDTH-1:0] ch0_real_i,
  input  logic signed [DATA_WIDTH-1:0] ch0_imag_i,
  output logic                         ch0_ready_o,
  input  logic                         ch1_valid_i,
  input  logic signed [DATA_WIDTH-1:0] ch1_real_i,
  input  logic signed [DATA_WIDTH-1:0] ch1_imag_i,
  output logic                         ch1_ready_o,
  output logic                         fft_valid_o,
  output logic signed [DATA_WIDTH-1:0] fft_real_o,
  output logic signed [DATA_WIDTH-1:0] fft_imag_o,
  input  logic                         core_valid_i,
  input  logic signed [OUT_WIDTH-1:0]  core_real_i,
  input  logic signed [OUT_WIDTH-1:0]  core_imag_i,
  output logic                         out_valid_o,
  output logic signed [OUT_WIDTH-1:0]  out_real_o,
  output logic signed [OUT_WIDTH-1:0]  out_imag_o,
  output logic                         out_ch_o,
  output logic [3:0]                   out_idx_o,
  output logic                         out_last_o,
  output logic                         busy_o,
  output logic                         underrun_o,
  output logic                         timeout_err_o
);

  if (TIMEOUT_CYCLES == 0) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic       grant;        // channel owning the current frame
  logic       last_served;  // round-robin pointer
  logic [3:0] load_cnt;
  logic [3:0] beat_cnt;

  logic [1:0]                   req;
  logic                         pick;
  logic                         sel_valid;
  logic signed [DATA_WIDTH-1:0] sel_real;
  logic signed [DATA_WIDTH-1:0] sel_imag;
  logic                         beat;
  logic                         abort;

  assign req  = {ch1_valid_i, ch0_valid_i};
  // A lone requester wins; on a tie the channel not served last wins.
  assign pick = (req == 2'b11) ? ~last_served : req[1];

  assign sel_valid = grant ? ch1_valid_i : ch0_valid_i;
  assign sel_real  = grant ? ch1_real_i  : ch0_real_i;
  assign sel_imag  = grant ? ch1_imag_i  : ch0_imag_i;

  // Core beats only count while a frame is waiting for results.
  assign beat = (state == WAIT) && core_valid_i;

`ifdef FFT16_SCHED_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wait_cnt;

  // Before the first beat: fire on the last allowed cycle without one.
  // After the first beat (beat_cnt != 0): any gap in core_valid_i fires.
  assign abort = (state == WAIT) && !core_valid_i &&
                 ((beat_cnt != 4'd0) || (wait_cnt == WD_W'(TIMEOUT_CYCLES - 1)));

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wait_cnt      <= '0;
      timeout_err_o <= 1'b0;
    end else begin
      timeout_err_o <= abort;
      if ((state != WAIT) || beat) begin
        wait_cnt <= '0;
      end else if (beat_cnt == 4'd0) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end
`else
  assign abort         = 1'b0;
  assign timeout_err_o = 1'b0;
`endif

  // State register
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req != 2'b00) state_nxt = LOAD;
      LOAD: if (load_cnt == 4'd15) state_nxt = WAIT;
      WAIT: if ((beat && (beat_cnt == 4'd15)) || abort) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    ch0_ready_o = (state == LOAD) && !grant;
    ch1_ready_o = (state == LOAD) && grant;
    busy_o      = (state != IDLE);
  end

  // Datapath: grant, counters, frame and result registers
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      grant       <= 1'b0;
      last_served <= 1'b1;
      load_cnt    <= '0;
      beat_cnt    <= '0;
      fft_valid_o <= 1'b0;
      fft_real_o  <= '0;
      fft_imag_o  <= '0;
      underrun_o  <= 1'b0;
      out_valid_o <= 1'b0;
      out_real_o  <= '0;
      out_imag_o  <= '0;
      out_ch_o    <= 1'b0;
      out_idx_o   <= '0;
      out_last_o  <= 1'b0;
    end else begin
      if ((state == IDLE) && (req != 2'b00)) begin
        grant       <= pick;
        last_served <= pick;
      end

      // Wraps 15->0 on the LOAD exit edge.
      load_cnt <= (state == LOAD) ? load_cnt + 4'd1 : 4'd0;

      fft_valid_o <= (state == LOAD);
      underrun_o  <= (state == LOAD) && !sel_valid;
      if ((state == LOAD) && sel_valid) begin
        fft_real_o <= sel_real;
        fft_imag_o <= sel_imag;
      end else begin
        fft_real_o <= '0;
        fft_imag_o <= '0;
      end

      out_valid_o <= beat;
      out_last_o  <= beat && (beat_cnt == 4'd15);
      if (beat) begin
        out_real_o <= core_real_i;
        out_imag_o <= core_imag_i;
        out_ch_o   <= grant;
        out_idx_o  <= beat_cnt;
      end

      if (state != WAIT) begin
        beat_cnt <= '0;
      end else if (beat) begin
        beat_cnt <= beat_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_fft16_frame_sched.sv
// Testbench for fft16_frame_sched: two randomized channel sources, a
// latency-20 core model, and a queue-based scoreboard fed at grant time
// from the frame plans and checked by an independent monitor.
module tb_fft16_frame_sched;

  localparam int CORE_LAT = 20;
  localparam int GUARD    = 3000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              drv_valid [2];
  logic signed [7:0] drv_re    [2];
  logic signed [7:0] drv_im    [2];
  logic              ch0_ready, ch1_ready;
  logic              fft_valid;
  logic signed [7:0] fft_re, fft_im;
  logic              core_valid;
  logic signed [17:0] core_re, core_im;
  logic              out_valid;
  logic signed [17:0] out_re, out_im;
  logic              out_ch;
  logic [3:0]        out_idx;
  logic              out_last, busy, underrun, timeout_err;

  fft16_frame_sched #(
    .DATA_WIDTH(8),
    .OUT_WIDTH(18),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .sys_clk_i(clk), .rst_n_i(rst_n),
    .ch0_valid_i(drv_valid[0]), .ch0_real_i(drv_re[0]), .ch0_imag_i(drv_im[0]), .ch0_ready_o(ch0_ready),
    .ch1_valid_i(drv_valid[1]), .ch1_real_i(drv_re[1]), .ch1_imag_i(drv_im[1]), .ch1_ready_o(ch1_ready),
    .fft_valid_o(fft_valid), .fft_real_o(fft_re), .fft_imag_o(fft_im),
    .core_valid_i(core_valid), .core_real_i(core_re), .core_imag_i(core_im),
    .out_valid_o(out_valid), .out_real_o(out_re), .out_imag_o(out_im),
    .out_ch_o(out_ch), .out_idx_o(out_idx), .out_last_o(out_last),
    .busy_o(busy), .underrun_o(underrun), .timeout_err_o(timeout_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Core model: each result bin is a fixed function of the input sample.
  function automatic logic [17:0] core_re_fn(input logic signed [7:0] x, input int k);
    return 18'(int'(x) * 3 + k);
  endfunction
  function automatic logic [17:0] core_im_fn(input logic signed [7:0] x, input int k);
    return 18'(int'(x) - 2 * k);
  endfunction

  typedef struct packed { logic [7:0] re; logic [7:0] im; logic und; } fft_exp_t;
  typedef struct packed { logic [17:0] re; logic [17:0] im; logic ch; logic [3:0] idx; logic last; } out_exp_t;

  fft_exp_t fft_q[$];
  out_exp_t out_q[$];

  logic [7:0] plan_re [2][16];
  logic [7:0] plan_im [2][16];
  bit         plan_v  [2][16];

  bit   m_in_frame = 0;
  bit   m_last     = 1;   // reference round-robin pointer: ch0 wins first tie
  bit   core_mute  = 0;
  int   rst_gen    = 0;
  logic [1:0] req_edge;

  always @(posedge clk) req_edge = {drv_valid[1], drv_valid[0]};

  // ---------------- channel source ----------------
  // mode 0: random data, occasional drops; 1: ramp 1..16 all valid;
  // mode 2: random data, valid dropped on frame cycles 5 and 6.
  task automatic drive_ch(input int ch, input int nframes, input int first_mode);
    int slot, guard, gap, mode;
    bit rdy_seen, rdy;
    for (int f = 0; f < nframes; f++) begin
      mode = (f == 0) ? first_mode : 0;
      gap  = (f == 0) ? 0 : int'($urandom_range(0, 3));
      for (int s = 0; s < 16; s++) begin
        plan_re[ch][s] = 8'($urandom);
        plan_im[ch][s] = 8'($urandom);
        plan_v[ch][s]  = ($urandom_range(0, 7) != 0);
        if (mode == 1) begin
          plan_re[ch][s] = 8'(s + 1);
          plan_v[ch][s]  = 1'b1;
        end
        if (mode == 2) plan_v[ch][s] = !((s == 4) || (s == 5));
      end
      if (gap != 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      drv_valid[ch] = 1'b1;
      drv_re[ch]    = 8'($urandom);
      drv_im[ch]    = 8'($urandom);
      slot = 0; rdy_seen = 0; guard = 0;
      while (slot < 16 && guard < GUARD) begin
        @(posedge clk);
        if (rdy_seen) slot++;
        #1;
        rdy      = (ch == 0) ? ch0_ready : ch1_ready;
        rdy_seen = rdy;
        if (rdy && slot < 16) begin
          drv_valid[ch] = plan_v[ch][slot];
          drv_re[ch]    = plan_v[ch][slot] ? plan_re[ch][slot] : 8'($urandom);
          drv_im[ch]    = plan_v[ch][slot] ? plan_im[ch][slot] : 8'($urandom);
        end else begin
          drv_valid[ch] = (slot < 16);
          drv_re[ch]    = 8'($urandom);
          drv_im[ch]    = 8'($urandom);
        end
        guard++;
      end
      chk(guard < GUARD, "source_frame_served", guard, GUARD);
    end
    drv_valid[ch] = 1'b0;
  endtask

  // ---------------- core model ----------------
  logic [15:0] col_q[$];
  int  col_n = 0;
  int  ready_frames = 0;
  bit  junk_ok = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      col_q.delete(); col_n = 0; ready_frames = 0; junk_ok = 0;
    end else if (fft_valid) begin
      col_q.push_back({fft_re, fft_im});
      col_n++;
      junk_ok = (col_n <= 14);   // DUT is still in LOAD next cycle
      if (col_n == 16) begin
        ready_frames++;
        col_n = 0;
      end
    end else begin
      junk_ok = 0;
    end
  end

  initial begin
    logic [15:0] s;
    int gen;
    core_valid = 1'b0; core_re = '0; core_im = '0;
    forever begin
      @(posedge clk); #1;
      core_valid = 1'b0;
      if (ready_frames > 0 && rst_n) begin
        ready_frames--;
        gen = rst_gen;
        if (core_mute) begin
          for (int i = 0; i < 16; i++) s = col_q.pop_front();
        end else begin
          repeat (CORE_LAT - 1) @(posedge clk);
          for (int k = 0; k < 16; k++) begin
`ifndef FFT16_SCHED_TIMEOUT_EN
            while ($urandom_range(0, 4) == 0) begin
              @(posedge clk); #1;
              core_valid = 1'b0;
            end
`endif
            @(posedge clk); #1;
            if (gen != rst_gen || col_q.size() == 0) begin
              core_valid = 1'b0;
              break;
            end
            s = col_q.pop_front();
            core_valid = 1'b1;
            core_re    = core_re_fn(s[15:8], k);
            core_im    = core_im_fn(s[7:0], k);
          end
        end
      end else if (junk_ok && $urandom_range(0, 2) == 0) begin
        core_valid = 1'b1;
        core_re    = 18'($urandom);
        core_im    = 18'($urandom);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int       run_len = 0;
  bit       exp_ch;
  fft_exp_t fe;
  out_exp_t oe;
  logic [7:0] xr, xi;

  always @(negedge clk) begin
    if (!rst_n) begin
      run_len = 0;
    end else begin
      if ((ch0_ready || ch1_ready) && !m_in_frame) begin
        exp_ch = (req_edge == 2'b11) ? ~m_last : req_edge[1];
        chk(req_edge != 2'b00, "grant_without_request", req_edge, 1);
        chk(!(ch0_ready && ch1_ready), "ready_onehot", {ch1_ready, ch0_ready}, exp_ch ? 2 : 1);
        chk(ch1_ready == exp_ch, "grant_channel", ch1_ready, exp_ch);
        chk(busy == 1'b1, "busy_in_load", busy, 1);
        m_last = exp_ch;
        m_in_frame = 1;
        for (int k = 0; k < 16; k++) begin
          xr = plan_v[exp_ch][k] ? plan_re[exp_ch][k] : 8'h00;
          xi = plan_v[exp_ch][k] ? plan_im[exp_ch][k] : 8'h00;
          fft_q.push_back('{re: xr, im: xi, und: !plan_v[exp_ch][k]});
          if (!core_mute)
            out_q.push_back('{re: core_re_fn(xr, k), im: core_im_fn(xi, k), ch: exp_ch, idx: 4'(k), last: (k == 15)});
        end
      end

      if (fft_valid) begin
        run_len++;
        if (fft_q.size() == 0) begin
          chk(1'b0, "fft_unexpected", fft_re, 0);
        end else begin
          fe = fft_q.pop_front();
          chk({fft_re, fft_im} == {fe.re, fe.im}, "fft_sample", {fft_re, fft_im}, {fe.re, fe.im});
          chk(underrun == fe.und, "underrun", underrun, fe.und);
        end
      end else begin
        chk(underrun == 1'b0, "underrun_idle", underrun, 0);
        if (run_len != 0) chk(run_len == 16, "fft_valid_run", run_len, 16);
        run_len = 0;
      end

      if (out_valid) begin
        if (out_q.size() == 0) begin
          chk(1'b0, "out_unexpected", out_idx, 0);
        end else begin
          oe = out_q.pop_front();
          chk({out_re, out_im} == {oe.re, oe.im}, "out_data", {out_re, out_im}, {oe.re, oe.im});
          chk(out_ch == oe.ch, "out_ch", out_ch, oe.ch);
          chk(out_idx == oe.idx, "out_idx", out_idx, oe.idx);
          chk(out_last == oe.last, "out_last", out_last, oe.last);
          if (oe.last) m_in_frame = 0;
        end
      end

`ifdef FFT16_SCHED_TIMEOUT_EN
      if (timeout_err) begin
        chk(core_mute, "timeout_unexpected", timeout_err, 0);
        m_in_frame = 0;
      end
`else
      chk(timeout_err == 1'b0, "timeout_tied_low", timeout_err, 0);
`endif
    end
  end

  // ---------------- sequencing ----------------
  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic quiesce(input string name);
    int b;
    b = 0;
    while ((out_q.size() != 0 || fft_q.size() != 0 || m_in_frame) && b < GUARD) begin
      @(negedge clk);
      b++;
    end
    chk(b < GUARD, name, b, GUARD);
    if (b >= GUARD) finish_test();
  endtask

  bit d0 = 0, d1 = 0;

  initial begin
    int b, w;
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      drv_valid[c] = 1'b0; drv_re[c] = '0; drv_im[c] = '0;
    end
    repeat (3) @(negedge clk);
    chk({fft_valid, fft_re, fft_im, underrun} == '0, "reset_fft_outputs", {fft_valid, fft_re, fft_im}, 0);
    chk({out_valid, out_re, out_im, out_ch, out_idx, out_last} == '0, "reset_out_outputs", {out_valid, out_idx}, 0);
    chk({ch0_ready, ch1_ready, busy, timeout_err} == '0, "reset_flags", {ch0_ready, ch1_ready, busy, timeout_err}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Both channels request together from reset: ramp frame on ch0,
    // drop-out frame on ch1, then random frames alternating.
    fork
      begin drive_ch(0, 4, 1); d0 = 1; end
      begin drive_ch(1, 4, 2); d1 = 1; end
    join_none
    b = 0;
    while (!(d0 && d1) && b < 20000) begin
      @(negedge clk);
      b++;
    end
    chk(d0 && d1, "random_phase_done", b, 20000);
    if (!(d0 && d1)) finish_test();
    quiesce("random_phase_drain");

    // Reset while result beat 7 is on the output.
    d0 = 0;
    fork
      begin drive_ch(0, 1, 0); d0 = 1; end
    join_none
    b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (!(out_valid && out_idx == 4'd7) && b < GUARD);
    chk(b < GUARD, "reset_test_beat7_seen", b, GUARD);
    #2;
    rst_n = 1'b0;
    rst_gen++;
    #1;
    chk({fft_valid, fft_re, fft_im, underrun} == '0, "midwait_reset_fft", {fft_valid, fft_re, fft_im}, 0);
    chk({out_valid, out_re, out_im, out_ch, out_idx, out_last} == '0, "midwait_reset_out", {out_valid, out_idx}, 0);
    chk({ch0_ready, ch1_ready, busy, timeout_err} == '0, "midwait_reset_flags", {ch0_ready, ch1_ready, busy, timeout_err}, 0);
    out_q.delete();
    fft_q.delete();
    m_in_frame = 0;
    m_last     = 1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk(!busy, "idle_after_reset", busy, 0);
    drive_ch(1, 1, 0);
    quiesce("post_reset_frame_drain");

`ifdef FFT16_SCHED_TIMEOUT_EN
    // Core never answers: watchdog fires 64 cycles after WAIT entry.
    core_mute = 1;
    fork
      drive_ch(0, 1, 0);
    join_none
    b = 0; w = 0;
    while (w < 16 && b < GUARD) begin
      @(negedge clk);
      b++;
      if (fft_valid) w++;
    end
    chk(w == 16, "timeout_frame_loaded", w, 16);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!timeout_err && w < 300);
    chk(w == 64, "timeout_latency", w, 64);
    chk(!busy, "idle_after_timeout", busy, 1'b0);
    @(negedge clk);
    chk(!timeout_err, "timeout_single_pulse", timeout_err, 0);
    core_mute = 0;
    quiesce("timeout_drain");
`else
    w = 0;
    b = 0;
`endif

    repeat (5) @(negedge clk);
    finish_test();
  end

endmodule
